// File: rtl/ysyx_wb_pkg.sv
// ysyx_wb_pkg -- shared types for the writeback arbiter.
//   wb_pkt_t : one completion packet handed to the reorder unit.
//   WB_W     : packed width of wb_pkt_t.
//   DEST_W   : ROB destination tag width (one extra bit for wrap/age).
// Core-width macros get defaults here so the slice builds stand-alone.
`ifndef YSYX_XLEN
`define YSYX_XLEN 64
`endif
`ifndef YSYX_PHY_LEN
`define YSYX_PHY_LEN 6
`endif
`ifndef YSYX_REG_LEN
`define YSYX_REG_LEN 5
`endif
`ifndef YSYX_ROB_SIZE
`define YSYX_ROB_SIZE 16
`endif

package ysyx_wb_pkg;

    localparam int PKG_XLEN = `YSYX_XLEN;
    localparam int PKG_PLEN = `YSYX_PHY_LEN;
    localparam int PKG_RLEN = `YSYX_REG_LEN;
    localparam int ROB_SIZE = `YSYX_ROB_SIZE;
    localparam int DEST_W   = $clog2(ROB_SIZE) + 1;

    typedef struct packed {
        logic [DEST_W-1:0]   dest;
        logic [PKG_PLEN-1:0] prd;
        logic [PKG_RLEN-1:0] rd;
        logic [PKG_XLEN-1:0] result;
        logic [PKG_XLEN-1:0] pc;
        logic [PKG_XLEN-1:0] npc;
        logic [31:0]         inst;
        logic                btaken;
        logic                csr_wen;
        logic [11:0]         csr_addr;
        logic [PKG_XLEN-1:0] csr_wdata;
        logic                ecall;
        logic                ebreak;
        logic                mret;
        logic                trap;
        logic [PKG_XLEN-1:0] tval;
        logic [PKG_XLEN-1:0] cause;
        logic                mem_wen;
        logic [PKG_XLEN-1:0] sq_waddr;
        logic [PKG_XLEN-1:0] sq_wdata;
    } wb_pkt_t;

    localparam int WB_W = $bits(wb_pkt_t);

endpackage

// File: rtl/ysyx_wb_fifo.sv
// ysyx_wb_fifo -- per-producer synchronous FIFO.
//   clk_i    : clock, rising edge
//   rst_ni   : synchronous active-low reset
//   flush_i  : empties the FIFO; a same-cycle push is discarded
//   push_i   : enqueue pkt_i (ignored while full)
//   pkt_i    : packet to enqueue
//   pop_i    : dequeue the head (ignored while empty)
//   head_o   : current head entry (valid when count_o != 0)
//   count_o  : number of stored entries, 0..DEPTH
//   full_o   : count_o == DEPTH
module ysyx_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [W-1:0]               pkt_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          wr_en;
    logic          rd_en;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign wr_en = rst_ni && !flush_i && push_i && !full_o;
    assign rd_en = rst_ni && !flush_i && pop_i && (count_q != '0);

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= pkt_i;
        end
    end

    // Pointers are log2(DEPTH) bits so they wrap for free.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ysyx_wb_arb.sv
// ysyx_wb_arb -- completion-side writeback scheduler.
// Buffers packets from NSRC producers in private FIFOs and grants the
// single ROB writeback port round-robin, one packet per cycle.
//   clock     : clock, rising edge
//   reset     : synchronous active-low reset
//   flush     : drop all buffered and same-cycle incoming packets
//   src_valid : per-producer packet valid
//   src_pkt   : per-producer packets, slot i at [i*WB_W +: WB_W]
//   src_ready : per-producer FIFO not full (registered count < DEPTH)
//   wb_valid  : a packet is presented to the ROB
//   wb_pkt    : presented packet
//   wb_src    : producer index of the presented packet
//   wb_ready  : ROB accepts the packet this cycle
//   ovf_err   : sticky, a producer pushed into a full FIFO
module ysyx_wb_arb
    import ysyx_wb_pkg::*;
#(
    parameter int NSRC  = 2,
    parameter int DEPTH = 2,
    parameter int XLEN  = `YSYX_XLEN,
    parameter int PLEN  = `YSYX_PHY_LEN,
    parameter int RLEN  = `YSYX_REG_LEN
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [NSRC-1:0]              src_valid,
    input  logic [NSRC*WB_W-1:0]         src_pkt,
    output logic [NSRC-1:0]              src_ready,
    output logic                         wb_valid,
    output logic [WB_W-1:0]              wb_pkt,
    output logic [$clog2(NSRC)-1:0]      wb_src,
    input  logic                         wb_ready,
    output logic                         ovf_err
);

    localparam int SW = $clog2(NSRC);
    localparam int CW = $clog2(DEPTH) + 1;

    // The packet layout is fixed by the package; the widths must agree.
    if (XLEN != PKG_XLEN || PLEN != PKG_PLEN || RLEN != PKG_RLEN
        || NSRC < 2 || NSRC > 4 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
        $error("ysyx_wb_arb: unsupported parameter combination");
    end

    logic [WB_W-1:0] head  [NSRC];
    logic [CW-1:0]   count [NSRC];
    logic [NSRC-1:0] full;
    logic [NSRC-1:0] req;
    logic [NSRC-1:0] pop;

    logic [SW-1:0]   rr_q,       rr_d;
    logic            lock_q;
    logic [SW-1:0]   lock_idx_q;
    logic            ovf_q;
    logic [SW-1:0]   grant;
    logic            fire;

    genvar gi;
    for (gi = 0; gi < NSRC; gi++) begin : g_src
        ysyx_wb_fifo #(
            .DEPTH (DEPTH),
            .W     (WB_W)
        ) u_fifo (
            .clk_i   (clock),
            .rst_ni  (reset),
            .flush_i (flush),
            .push_i  (src_valid[gi]),
            .pkt_i   (src_pkt[gi*WB_W +: WB_W]),
            .pop_i   (pop[gi]),
            .head_o  (head[gi]),
            .count_o (count[gi]),
            .full_o  (full[gi])
        );
        assign req[gi]       = (count[gi] != '0);
        assign src_ready[gi] = !full[gi];
        assign pop[gi]       = fire && (grant == SW'(gi));
    end

    // First requester at or after rr_q, wrapping modulo NSRC. While a
    // packet is stalled the grant is pinned so a late push on a higher
    // priority producer cannot swap the presented packet.
    always_comb begin
        logic found;
        int   idx;
        grant = rr_q;
        found = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NSRC) idx = idx - NSRC;
            if (!found && req[idx]) begin
                found = 1'b1;
                grant = SW'(idx);
            end
        end
        if (lock_q) grant = lock_idx_q;
    end

    assign wb_valid = |req;
    assign wb_pkt   = head[grant];
    assign wb_src   = grant;
    assign fire     = wb_valid && wb_ready;
    assign ovf_err  = ovf_q;

    always_comb begin
        rr_d = rr_q;
        if (fire) begin
            rr_d = (int'(grant) == NSRC - 1) ? '0 : grant + 1'b1;
        end
    end

    // A pop in the flush cycle is still a delivery, so rr advances then too.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= wb_valid && !wb_ready && !flush;
            lock_idx_q <= grant;
            if (|(src_valid & full)) ovf_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ysyx_wb_arb.sv
module tb_ysyx_wb_arb;
    import ysyx_wb_pkg::*;

    localparam int NSRC  = 2;
    localparam int DEPTH = 2;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 flush;
    logic [NSRC-1:0]      src_valid;
    logic [NSRC*WB_W-1:0] src_pkt;
    logic [NSRC-1:0]      src_ready;
    logic                 wb_valid;
    logic [WB_W-1:0]      wb_pkt;
    logic [0:0]           wb_src;
    logic                 wb_ready;
    logic                 ovf_err;

    ysyx_wb_arb #(.NSRC(NSRC), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .src_valid (src_valid),
        .src_pkt   (src_pkt),
        .src_ready (src_ready),
        .wb_valid  (wb_valid),
        .wb_pkt    (wb_pkt),
        .wb_src    (wb_src),
        .wb_ready  (wb_ready),
        .ovf_err   (ovf_err)
    );

    always #5 clock = ~clock;

    // Reference model: one queue per producer plus round-robin pointer.
    wb_pkt_t mq [NSRC][$];
    int      rr_m;
    bit      held_m;
    int      held_idx_m;
    bit      ovf_m;
    int      obs_dest [$];
    int      checks = 0;
    int      errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic wb_pkt_t rand_pkt(input int d);
        logic [WB_W-1:0] v;
        wb_pkt_t p;
        for (int b = 0; b < WB_W; b++) v[b] = 1'($urandom);
        p = v;
        p.dest = DEST_W'(d);
        return p;
    endfunction

    // Presented producer: pinned while stalled, else first non-empty from rr.
    function automatic int exp_grant();
        if (held_m) return held_idx_m;
        for (int k = 0; k < NSRC; k++) begin
            if (mq[(rr_m + k) % NSRC].size() != 0) return (rr_m + k) % NSRC;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NSRC; i++) mq[i].delete();
        rr_m = 0; held_m = 0; held_idx_m = 0; ovf_m = 0;
    endtask

    task automatic cyc(input bit rst_n, input bit fl, input bit [1:0] v,
                       input wb_pkt_t p0, input wb_pkt_t p1, input bit rdy);
        int      g;
        bit      was_full [NSRC];
        wb_pkt_t got_p;
        reset = rst_n; flush = fl; src_valid = v; src_pkt = {p1, p0}; wb_ready = rdy;
        @(negedge clock);
        g = exp_grant();
        got_p = wb_pkt;
        check("wb_valid", 64'(wb_valid), 64'(g >= 0));
        for (int i = 0; i < NSRC; i++)
            check($sformatf("src_ready%0d", i), 64'(src_ready[i]), 64'(mq[i].size() < DEPTH));
        check("ovf_err", 64'(ovf_err), 64'(ovf_m));
        if (g >= 0) begin
            check("wb_src", 64'(wb_src), 64'(g));
            check("wb_dest", 64'(got_p.dest), 64'(mq[g][0].dest));
            check("wb_pkt_eq", 64'(got_p == mq[g][0]), 64'd1);
        end
        if (wb_valid && rdy) obs_dest.push_back(int'(got_p.dest));
        @(posedge clock);
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < NSRC; i++) was_full[i] = (mq[i].size() >= DEPTH);
            if (g >= 0 && rdy) begin
                void'(mq[g].pop_front());
                rr_m = (g + 1) % NSRC;
            end
            held_m     = (g >= 0) && !rdy && !fl;
            held_idx_m = g;
            for (int i = 0; i < NSRC; i++) if (v[i] && was_full[i]) ovf_m = 1;
            if (fl) begin
                for (int i = 0; i < NSRC; i++) mq[i].delete();
            end else begin
                if (v[0] && !was_full[0]) mq[0].push_back(p0);
                if (v[1] && !was_full[1]) mq[1].push_back(p1);
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++) cyc(1, 0, 2'b00, rand_pkt(0), rand_pkt(0), rdy);
    endtask

    initial begin
        int  found30;
        bit  r, f, rd;
        bit [1:0] v;
        reset = 0; flush = 0; src_valid = '0; src_pkt = '0; wb_ready = 0;
        model_reset();
        @(posedge clock); #1;

        // Reset held with traffic, then idle.
        cyc(0, 0, 2'b11, rand_pkt(1), rand_pkt(2), 1);
        cyc(0, 0, 2'b11, rand_pkt(1), rand_pkt(2), 1);
        idle(3, 1);

        // Single-source latency.
        obs_dest.delete();
        cyc(1, 0, 2'b01, rand_pkt(5), rand_pkt(0), 1);
        idle(2, 1);
        check("latency_cnt", 64'(obs_dest.size()), 64'd1);
        if (obs_dest.size() == 1) check("latency_dest", 64'(obs_dest[0]), 64'd5);

        // Round-robin fairness from rr=0.
        cyc(0, 0, 2'b00, rand_pkt(0), rand_pkt(0), 1);
        obs_dest.delete();
        cyc(1, 0, 2'b11, rand_pkt(1), rand_pkt(9), 1);
        cyc(1, 0, 2'b11, rand_pkt(2), rand_pkt(10), 1);
        idle(4, 1);
        check("rr_cnt", 64'(obs_dest.size()), 64'd4);
        if (obs_dest.size() == 4) begin
            check("rr_0", 64'(obs_dest[0]), 64'd1);
            check("rr_1", 64'(obs_dest[1]), 64'd9);
            check("rr_2", 64'(obs_dest[2]), 64'd2);
            check("rr_3", 64'(obs_dest[3]), 64'd10);
        end

        // Backpressure with src0 full and a forced overflow push.
        cyc(0, 0, 2'b00, rand_pkt(0), rand_pkt(0), 1);
        obs_dest.delete();
        cyc(1, 0, 2'b01, rand_pkt(3), rand_pkt(0), 0);
        cyc(1, 0, 2'b01, rand_pkt(4), rand_pkt(0), 0);
        cyc(1, 0, 2'b00, rand_pkt(0), rand_pkt(0), 0);
        cyc(1, 0, 2'b01, rand_pkt(30), rand_pkt(0), 0);
        cyc(1, 0, 2'b00, rand_pkt(0), rand_pkt(0), 0);
        cyc(1, 0, 2'b00, rand_pkt(0), rand_pkt(0), 0);
        check("ovf_set", 64'(ovf_err), 64'd1);
        idle(4, 1);
        found30 = 0;
        foreach (obs_dest[k]) if (obs_dest[k] == 30) found30++;
        check("ovf_dropped", 64'(found30), 64'd0);
        check("bp_cnt", 64'(obs_dest.size()), 64'd2);

        // Flush with a same-cycle push.
        cyc(0, 0, 2'b00, rand_pkt(0), rand_pkt(0), 1);
        cyc(1, 0, 2'b11, rand_pkt(11), rand_pkt(12), 0);
        cyc(1, 0, 2'b11, rand_pkt(13), rand_pkt(14), 0);
        obs_dest.delete();
        cyc(1, 1, 2'b11, rand_pkt(50), rand_pkt(51), 0);
        idle(3, 1);
        check("flush_cnt", 64'(obs_dest.size()), 64'd0);

        // Reset mid-stream, then src0 wins first from rr=0.
        cyc(1, 0, 2'b11, rand_pkt(20), rand_pkt(21), 0);
        cyc(1, 0, 2'b01, rand_pkt(22), rand_pkt(0), 0);
        cyc(0, 0, 2'b11, rand_pkt(23), rand_pkt(24), 0);
        obs_dest.delete();
        cyc(1, 0, 2'b11, rand_pkt(7), rand_pkt(8), 1);
        idle(3, 1);
        check("rst_cnt", 64'(obs_dest.size()), 64'd2);
        if (obs_dest.size() >= 1) check("rst_first", 64'(obs_dest[0]), 64'd7);

        // Randomised traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            r  = ($urandom_range(0, 99) != 0);
            f  = ($urandom_range(0, 19) == 0);
            rd = ($urandom_range(0, 3) != 0);
            v  = 2'($urandom);
            for (int i = 0; i < NSRC; i++)
                if (!src_ready[i] && $urandom_range(0, 9) != 0) v[i] = 1'b0;
            cyc(r, f, v, rand_pkt($urandom_range(0, 31)), rand_pkt($urandom_range(0, 31)), rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
